// File: rtl/requant_ctrl.sv
// Requantizer sequencer: arm/sync FSM, double-buffered gain table,
// frame-aligned bank swap and per-frame overflow accounting.
`timescale 1ns/1ps
module requant_ctrl #(
  parameter int CHANNELS = 2048,
  parameter int ADDR_W   = 11,
  parameter int GAIN_W   = 5,
  parameter int CNT_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              host_arm,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [GAIN_W-1:0] wr_data,
  input  logic              commit,
  input  logic              sync_in,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_overflow,
  output logic [GAIN_W-1:0] gain_out,
  output logic              arm_out,
  output logic              running,
  output logic              active_bank,
  output logic              swap_pending,
  output logic [CNT_W-1:0]  ovf_count,
  output logic              ovf_count_valid,
  output logic              ovf_sticky,
  input  logic              ovf_clear
);

  typedef enum logic [1:0] {
    IDLE, ARM, WAIT_SYNC, RUN
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0]  CMAX = '1;

  state_t            state;
  logic [ADDR_W-1:0] chan;
  logic [CNT_W-1:0]  accum;
  logic              first_zero;
  logic [GAIN_W-1:0] mem [2*CHANNELS];

  logic              in_run;
  logic              chan_zero;
  logic              do_swap;
  logic [CNT_W:0]    sum;
  logic [CNT_W-1:0]  sum_sat;

  assign in_run    = (state == RUN);
  assign chan_zero = (chan == '0);
  assign do_swap   = swap_pending && (!in_run || chan == LAST);
  assign sum       = {1'b0, accum} + (CNT_W+1)'(req_overflow);
  assign sum_sat   = sum[CNT_W] ? CMAX : sum[CNT_W-1:0];

  // Writes always target the shadow bank, even on the swap edge
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{~active_bank, wr_addr}] <= wr_data;
  end

  assign gain_out = mem[{active_bank, req_addr}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      chan            <= '0;
      accum           <= '0;
      first_zero      <= 1'b1;
      arm_out         <= 1'b0;
      running         <= 1'b0;
      active_bank     <= 1'b0;
      swap_pending    <= 1'b0;
      ovf_count       <= '0;
      ovf_count_valid <= 1'b0;
      ovf_sticky      <= 1'b0;
    end else begin
      ovf_count_valid <= 1'b0;
      if (ce) begin
        unique case (state)
          IDLE: begin
            if (host_arm) begin
              state   <= ARM;
              arm_out <= 1'b1;
            end
          end
          ARM: begin
            state   <= WAIT_SYNC;
            arm_out <= 1'b0;
          end
          WAIT_SYNC: begin
            if (sync_in) begin
              state      <= RUN;
              running    <= 1'b1;
              chan       <= '0;
              first_zero <= 1'b1;
            end
          end
          RUN: chan <= chan + 1'b1;
          default: state <= IDLE;
        endcase

        if (do_swap) begin
          active_bank  <= ~active_bank;
          swap_pending <= commit;
        end else if (commit) begin
          swap_pending <= 1'b1;
        end

        // Channel 0 closes the frame whose last overflow arrives now
        if (in_run) begin
          if (chan_zero) begin
            accum      <= '0;
            first_zero <= 1'b0;
            if (!first_zero) begin
              ovf_count       <= sum_sat;
              ovf_count_valid <= 1'b1;
            end
          end else begin
            accum <= sum_sat;
          end
        end

        if (in_run && req_overflow && !(chan_zero && first_zero))
          ovf_sticky <= 1'b1;
        else if (ovf_clear)
          ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_requant_ctrl.sv
// Bench for requant_ctrl: gain table vectors, FSM/swap sequences,
// overflow-count scoreboard.
`timescale 1ns/1ps
module tb_requant_ctrl;

  localparam int CH = 2048;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        host_arm;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [4:0]  wr_data;
  logic        commit;
  logic        sync_in;
  logic [10:0] req_addr;
  logic        req_overflow;
  logic [4:0]  gain_out;
  logic        arm_out;
  logic        running;
  logic        active_bank;
  logic        swap_pending;
  logic [11:0] ovf_count;
  logic        ovf_count_valid;
  logic        ovf_sticky;
  logic        ovf_clear;

  requant_ctrl #(
    .CHANNELS(CH), .ADDR_W(11), .GAIN_W(5), .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .host_arm(host_arm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .sync_in(sync_in), .req_addr(req_addr),
    .req_overflow(req_overflow), .gain_out(gain_out),
    .arm_out(arm_out), .running(running),
    .active_bank(active_bank), .swap_pending(swap_pending),
    .ovf_count(ovf_count), .ovf_count_valid(ovf_count_valid),
    .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] addr;
    logic [4:0]  gain;
  } rd_vec_t;

  rd_vec_t t1 [5];
  rd_vec_t t0 [4];

  int errors = 0;
  int checks = 0;
  int sb [$];

  int  m_cnt   = 0;
  int  m_frame = 0;
  int  m_acc   = 0;
  bit  m_run   = 1'b0;
  bit  m_first = 1'b0;
  bit  froze   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; scoreboard follows the frame accounting rules
  task automatic tick();
    bit exp_v;
    int exp_c;
    @(posedge clk);
    exp_v = 1'b0;
    if (ce && m_run) begin
      if (m_cnt == 0) begin
        if (m_first) begin
          m_first = 1'b0;
        end else begin
          sb.push_back(m_acc + int'(req_overflow));
          exp_v = 1'b1;
        end
        m_acc = 0;
      end else begin
        m_acc = m_acc + int'(req_overflow);
      end
      if (m_cnt == CH - 1) m_frame++;
      m_cnt = (m_cnt + 1) % CH;
    end
    #1;
    if (ovf_count_valid || exp_v) begin
      chk("ovf_valid", 32'(ovf_count_valid), 32'(exp_v));
      if (ovf_count_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ovf_count: got %0d expected no pulse",
                   ovf_count);
        end else begin
          exp_c = sb.pop_front();
          chk("ovf_count", 32'(ovf_count), 32'(exp_c));
        end
      end
    end
  endtask

  initial begin
    t1[0] = '{11'd37,   5'd5};
    t1[1] = '{11'd0,    5'd0};
    t1[2] = '{11'd31,   5'd31};
    t1[3] = '{11'd32,   5'd0};
    t1[4] = '{11'd2047, 5'd31};
    t0[0] = '{11'd0,    5'd7};
    t0[1] = '{11'd5,    5'd21};
    t0[2] = '{11'd40,   5'd15};
    t0[3] = '{11'd2047, 5'd6};

    rst = 1'b1; ce = 1'b1; host_arm = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; commit = 1'b0; sync_in = 1'b0;
    req_addr = '0; req_overflow = 1'b0; ovf_clear = 1'b0;
    tick();
    tick();
    chk("rst_arm", 32'(arm_out), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_bank", 32'(active_bank), 0);
    chk("rst_pending", 32'(swap_pending), 0);
    chk("rst_count", 32'(ovf_count), 0);
    chk("rst_valid", 32'(ovf_count_valid), 0);
    chk("rst_sticky", 32'(ovf_sticky), 0);
    rst = 1'b0;

    for (int c = 0; c < CH; c++) begin
      wr_en = 1'b1; wr_addr = 11'(c); wr_data = 5'(c % 32);
      tick();
    end
    wr_en = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("idle_commit_pending", 32'(swap_pending), 1);
    chk("idle_commit_bank", 32'(active_bank), 0);
    tick();
    chk("idle_swap_bank", 32'(active_bank), 1);
    chk("idle_swap_pending", 32'(swap_pending), 0);
    for (int i = 0; i < 5; i++) begin
      req_addr = t1[i].addr;
      #1;
      chk($sformatf("bank1_gain[%0d]", t1[i].addr),
          32'(gain_out), 32'(t1[i].gain));
    end

    for (int c = 0; c < CH; c++) begin
      wr_en = 1'b1; wr_addr = 11'(c); wr_data = 5'((c + 7) % 32);
      tick();
    end
    wr_en = 1'b0;

    sync_in = 1'b1;
    tick();
    chk("idle_sync_ignored", 32'(running), 0);
    sync_in = 1'b0;
    host_arm = 1'b1;
    tick();
    host_arm = 1'b0;
    chk("arm_high", 32'(arm_out), 1);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    chk("arm_one_cycle", 32'(arm_out), 0);
    chk("arm_sync_ignored", 32'(running), 0);
    tick();
    chk("wait_sync_hold", 32'(running), 0);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    chk("run_entry", 32'(running), 1);
    m_run = 1'b1; m_first = 1'b1; m_cnt = 0; m_frame = 0; m_acc = 0;

    while (!(m_frame == 2 && m_cnt == 20)) begin
      req_overflow = 1'b0; commit = 1'b0; ovf_clear = 1'b0;
      if (m_frame == 0) begin
        if (m_cnt >= 10 && m_cnt <= 12) req_overflow = 1'b1;
        if (m_cnt == 100 || m_cnt == 500) commit = 1'b1;
      end else if (m_frame == 1) begin
        if (m_cnt == 3) begin req_overflow = 1'b1; ovf_clear = 1'b1; end
        if (m_cnt == 50) ovf_clear = 1'b1;
        if (m_cnt == 200 || m_cnt == 201) req_overflow = 1'b1;
        if (m_cnt == 1000) commit = 1'b1;
      end else begin
        if (m_cnt == 0) req_overflow = 1'b1;
        if (m_cnt == 10) commit = 1'b1;
      end

      if (m_frame == 0 && m_cnt == 300 && !froze) begin
        froze = 1'b1;
        ce = 1'b0;
        for (int k = 0; k < 10; k++) begin
          req_overflow = 1'b1; sync_in = 1'b1; host_arm = 1'b1;
          wr_en = (k == 0); wr_addr = 11'd5; wr_data = 5'd21;
          tick();
        end
        wr_en = 1'b0; sync_in = 1'b0; host_arm = 1'b0;
        req_overflow = 1'b0;
        chk("freeze_running", 32'(running), 1);
        chk("freeze_pending", 32'(swap_pending), 1);
        ce = 1'b1;
      end

      tick();

      if (m_frame == 0 && m_cnt == 13)
        chk("sticky_set", 32'(ovf_sticky), 1);
      if (m_frame == 0 && m_cnt == 101) begin
        chk("run_commit_pending", 32'(swap_pending), 1);
        chk("run_commit_bank", 32'(active_bank), 1);
      end
      if (m_frame == 0 && m_cnt == 2047) begin
        chk("pre_swap_pending", 32'(swap_pending), 1);
        chk("pre_swap_bank", 32'(active_bank), 1);
      end
      if (m_frame == 1 && m_cnt == 0) begin
        chk("swap_bank", 32'(active_bank), 0);
        chk("swap_pending_clr", 32'(swap_pending), 0);
        for (int i = 0; i < 4; i++) begin
          req_addr = t0[i].addr;
          #1;
          chk($sformatf("bank0_gain[%0d]", t0[i].addr),
              32'(gain_out), 32'(t0[i].gain));
        end
      end
      if (m_frame == 1 && m_cnt == 4)
        chk("sticky_set_wins", 32'(ovf_sticky), 1);
      if (m_frame == 1 && m_cnt == 51)
        chk("sticky_clear", 32'(ovf_sticky), 0);
      if (m_frame == 1 && m_cnt == 900) begin
        chk("no_double_toggle", 32'(active_bank), 0);
        chk("no_double_pending", 32'(swap_pending), 0);
      end
      if (m_frame == 1 && m_cnt == 1001)
        chk("commit2_pending", 32'(swap_pending), 1);
      if (m_frame == 2 && m_cnt == 5) begin
        chk("swap2_bank", 32'(active_bank), 1);
        chk("swap2_pending", 32'(swap_pending), 0);
        chk("sticky_reset_again", 32'(ovf_sticky), 1);
      end
      if (m_frame == 2 && m_cnt == 11)
        chk("commit3_pending", 32'(swap_pending), 1);
    end

    req_overflow = 1'b0; commit = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_running", 32'(running), 0);
    chk("arst_arm", 32'(arm_out), 0);
    chk("arst_bank", 32'(active_bank), 0);
    chk("arst_pending", 32'(swap_pending), 0);
    chk("arst_count", 32'(ovf_count), 0);
    chk("arst_sticky", 32'(ovf_sticky), 0);
    m_run = 1'b0; m_acc = 0;
    tick();
    rst = 1'b0;
    chk("sb_drained", 32'(sb.size()), 0);
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    chk("post_rst_idle", 32'(running), 0);
    chk("post_rst_arm", 32'(arm_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/requant_ctrl.md
Name: requant_ctrl

Overview:
- Sequencer and gain-table owner for the requantizer stage.
- Holds a double-buffered per-channel gain table. Host writes the shadow bank; the bank swap is committed on a frame boundary so that no frame ever mixes gains from two banks.
- Generates the requantizer arm pulse and tracks the running frame/channel position.
- Serves the gain for the requantizer's address and aggregates its overflow flag into per-frame counts and a sticky flag.

Parameters:
- CHANNELS, 2048, channels per frame (power of two)
- ADDR_W, 11, log2(CHANNELS)
- GAIN_W, 5, gain word width
- CNT_W, 12, per-frame overflow count width (must hold CHANNELS)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ce  in  1  clock enable; all FSM/counter/bank/overflow updates occur only when ce=1
- host_arm  in  1  request to start requant sequencing
- wr_en  in  1  shadow-bank write strobe (not ce-gated)
- wr_addr  in  ADDR_W  shadow-bank write channel
- wr_data  in  GAIN_W  shadow-bank write gain
- commit  in  1  request bank swap
- sync_in  in  1  frame sync, same signal the requantizer sees
- req_addr  in  ADDR_W  channel address from the requantizer
- req_overflow  in  1  registered overflow from the requantizer
- gain_out  out  GAIN_W  active_bank[req_addr], combinational read
- arm_out  out  1  arm pulse to the requantizer
- running  out  1  FSM in RUN
- active_bank  out  1  bank currently served on gain_out
- swap_pending  out  1  commit accepted, swap not yet done
- ovf_count  out  CNT_W  overflow count of the last completed frame
- ovf_count_valid  out  1  one-cycle pulse when ovf_count updates
- ovf_sticky  out  1  any overflow since last clear
- ovf_clear  in  1  clears ovf_sticky

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - arm_out, running, active_bank, swap_pending, ovf_count, ovf_count_valid and ovf_sticky = 0.
  - Channel counter and overflow accumulator = 0.
  - Gain RAM contents are not reset; gain_out is undefined until the table is written.
- Gain RAM:
  - 2 x CHANNELS x GAIN_W, asynchronous read.
  - Write: when wr_en=1, wr_data is written to bank ~active_bank at wr_addr on the clk edge, regardless of ce.
  - Write on the swap edge: the write uses the pre-edge ~active_bank, i.e. it lands in the bank becoming active.
- FSM (advances on ce=1 only):
  - IDLE: if host_arm=1, go to ARM.
  - ARM: arm_out=1 for exactly this one ce-cycle (registered, so arm_out is high for the cycle after the transition edge); go to WAIT_SYNC.
  - WAIT_SYNC: if sync_in=1, go to RUN; the channel counter is set to 0.
  - RUN: running=1. The channel counter increments each ce-cycle and wraps from CHANNELS-1 to 0, mirroring the requantizer's channel count. host_arm and sync_in are ignored; only rst leaves RUN.
  - sync_in in IDLE or ARM is ignored.
- Bank swap:
  - commit=1 on a ce-cycle sets swap_pending. A commit while swap_pending is already set has no additional effect.
  - In RUN: the swap (active_bank toggles, swap_pending clears) occurs on the ce edge where the channel counter == CHANNELS-1, so channel 0 of the next frame reads the new bank.
  - Not in RUN: the swap occurs on the next ce edge after swap_pending is set.
  - commit on the same cycle as the swap edge is taken as a new request and leaves swap_pending=1 after the edge.
- Overflow accounting (RUN, ce=1):
  - req_overflow lags the channel by one cycle.
  - On channel counter == 0: ovf_count <= accum + req_overflow, accum <= 0, ovf_count_valid pulses for 1 cycle.
  - The first counter==0 after entering RUN clears accum but does not update ovf_count or pulse ovf_count_valid.
  - Otherwise, accum += req_overflow (saturating at 2^CNT_W-1).
  - ovf_sticky is set by any req_overflow=1 counted in RUN and cleared by ovf_clear=1. If set and clear occur in the same cycle, set wins.
- rst asserted mid-frame aborts immediately. active_bank returns to 0 (host must rewrite both banks); any pending swap is dropped.

Test Plan:
- Reset, then write bank 1 with gain[c]=c%32 and commit while IDLE -> active_bank=1 one ce-cycle later, swap_pending=0; gain_out for req_addr=37 is 5.
- host_arm pulse -> arm_out high exactly one cycle, state WAIT_SYNC; sync_in ignored before ARM; a sync_in after ARM -> running=1 the next cycle.
- In RUN, commit at channel 100 -> swap_pending=1 until the edge at channel 2047; active_bank toggles exactly there; channel 0 of the next frame reads the new gain; a second commit meanwhile causes no double toggle.
- req_overflow=1 for 3 cycles within one frame -> at the next counter==0, ovf_count=3 with a one-cycle ovf_count_valid; the first frame after RUN entry produces no valid pulse.
- ovf_clear and req_overflow asserted together -> ovf_sticky stays 1; ovf_clear alone -> 0.
- ce held low for 10 cycles in RUN -> counter, FSM and accum are frozen, while a wr_en write still lands in the shadow bank; rst mid-frame -> all outputs 0 and state IDLE asynchronously.
